// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle for the register-file write arbiter.
// Carries the packed per-requester valid/address/data lanes and the
// one-hot ready pulse returned by the arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 64
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    // Requester side: presents writes, observes the accept pulse
    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    // Arbiter side: samples requests, returns the accept pulse
    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port.
// One requester is accepted per cycle; the accepted address/data pair is
// registered and presented with a one-cycle write strobe on the next edge.
// Optional feature: define REGFILE_ARB_ZERO_REG_EN to make register 0
// hard-wired zero (writes to address 0 are accepted but never strobed).
module regfile_write_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned GID_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_write_arbiter_if.slave req,
    input  logic                  hold,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [GID_W-1:0]      grant_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state;
    logic [GID_W-1:0]  rr_ptr;

    logic              sel_found;
    logic [GID_W-1:0]  sel_idx;
    logic [GID_W-1:0]  cand_idx;
    logic              accept;
    logic              strobe;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Search for the first valid requester starting just after rr_ptr
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_idx = GID_W'((32'(rr_ptr) + k) % N_REQ);
            if (!sel_found && req.req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Acceptance is suppressed while the file is busy or held in reset
    always_comb begin
        accept        = sel_found && !hold && rst_n;
        req.req_ready = '0;
        if (accept) begin
            req.req_ready = N_REQ'(1) << sel_idx;
        end
    end

    // Route the winner's address/data lane toward the output registers
    always_comb begin
        sel_addr = req.req_addr[sel_idx*ADDR_W +: ADDR_W];
        sel_data = req.req_data[sel_idx*DATA_W +: DATA_W];
    end

`ifdef REGFILE_ARB_ZERO_REG_EN
    // Address 0 is consumed without a strobe; the pointer still advances
    always_comb begin
        strobe = accept && (sel_addr != '0);
    end
`else
    // Every accepted request produces a write strobe
    always_comb begin
        strobe = accept;
    end
`endif

    // Write FSM with registered strobe, address, data and grant owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= GID_W'(N_REQ - 1);
        end else begin
            if (accept) begin
                rr_ptr <= sel_idx;
            end
            case (state)
                IDLE: begin
                    if (strobe) begin
                        state    <= WRITE;
                        wr_en    <= 1'b1;
                        wr_addr  <= sel_addr;
                        wr_data  <= sel_data;
                        grant_id <= sel_idx;
                    end else begin
                        state <= IDLE;
                        wr_en <= 1'b0;
                    end
                end
                WRITE: begin
                    if (strobe) begin
                        state    <= WRITE;
                        wr_en    <= 1'b1;
                        wr_addr  <= sel_addr;
                        wr_data  <= sel_data;
                        grant_id <= sel_idx;
                    end else begin
                        state <= IDLE;
                        wr_en <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Handshake invariants: never more than one accept, none while busy
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req.req_ready));
    a_ready_hold: assert property (@(posedge clk) disable iff (!rst_n)
        hold |-> (req.req_ready == '0));
    a_state_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en == (state == WRITE));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with N_REQ=4, ADDR_W=3, DATA_W=64.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  grant_id;

    int errors = 0;
    int checks = 0;

    logic        exp_en;
    logic [2:0]  exp_addr;

    regfile_write_arbiter_if #(.N_REQ(4), .ADDR_W(3), .DATA_W(64)) rif ();

    regfile_write_arbiter #(.N_REQ(4), .ADDR_W(3), .DATA_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (rif.slave),
        .hold     (hold),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        hold          = 1'b0;
        rif.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            rif.req_addr[i*3 +: 3]   = 3'(i + 1);
            rif.req_data[i*64 +: 64] = 64'hA0 + 64'(i);
        end

        // Reset holds everything quiet even with all requesters valid
        @(negedge clk);
        #1;
        check("rst_ready", rif.req_ready, 4'b0000);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_rr_ptr", dut.rr_ptr, 3);

        // Release reset; all four valid -> 0,1,2,3,0,1,2,3 back to back
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("rr_ready", rif.req_ready, 64'(1) << (c % 4));
            after_edge();
            check("rr_wr_en", wr_en, 1);
            check("rr_grant", grant_id, 64'(c % 4));
            check("rr_addr", wr_addr, 64'(c % 4 + 1));
            check("rr_data", wr_data, 64'hA0 + 64'(c % 4));
        end

        // Idle: strobe drops, address/grant keep last values
        @(negedge clk);
        rif.req_valid = 4'b0000;
        #1;
        check("idle_ready", rif.req_ready, 0);
        after_edge();
        check("idle_wr_en", wr_en, 0);
        check("idle_addr_kept", wr_addr, 4);
        check("idle_grant_kept", grant_id, 3);

        // Single request from requester 2
        @(negedge clk);
        rif.req_valid             = 4'b0100;
        rif.req_addr[6 +: 3]      = 3'd5;
        rif.req_data[128 +: 64]   = 64'hDEAD_BEEF;
        #1;
        check("single_ready", rif.req_ready, 4'b0100);
        after_edge();
        check("single_wr_en", wr_en, 1);
        check("single_addr", wr_addr, 5);
        check("single_data", wr_data, 64'hDEAD_BEEF);
        check("single_grant", grant_id, 2);
        @(negedge clk);
        rif.req_valid = 4'b0000;
        after_edge();
        check("single_done", wr_en, 0);

        // Hold blocks requester 1 for three cycles
        @(negedge clk);
        rif.req_valid = 4'b0010;
        hold          = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("hold_ready", rif.req_ready, 0);
            after_edge();
            check("hold_wr_en", wr_en, 0);
        end
        @(negedge clk);
        hold = 1'b0;
        #1;
        check("unhold_ready", rif.req_ready, 4'b0010);
        after_edge();
        check("unhold_wr_en", wr_en, 1);
        check("unhold_grant", grant_id, 1);

        // Pointer at 1: requesters 0 and 3 valid -> 3 wins, then wrap to 0
        @(negedge clk);
        rif.req_valid = 4'b1001;
        #1;
        check("wrap_ready3", rif.req_ready, 4'b1000);
        after_edge();
        check("wrap_grant3", grant_id, 3);
        @(negedge clk);
        rif.req_valid = 4'b0001;
        #1;
        check("wrap_ready0", rif.req_ready, 4'b0001);
        after_edge();
        check("wrap_wr_en0", wr_en, 1);
        check("wrap_grant0", grant_id, 0);

        // Hold raised while in WRITE: strobe ends, request waits
        @(negedge clk);
        rif.req_valid = 4'b0100;
        hold          = 1'b1;
        #1;
        check("holdw_ready", rif.req_ready, 0);
        after_edge();
        check("holdw_wr_en", wr_en, 0);
        @(negedge clk);
        hold = 1'b0;
        #1;
        check("holdw_ready2", rif.req_ready, 4'b0100);
        after_edge();
        check("holdw_grant", grant_id, 2);
        check("holdw_addr", wr_addr, 5);

        // Requester 3 writes address 0
        @(negedge clk);
        rif.req_valid           = 4'b1000;
        rif.req_addr[9 +: 3]    = 3'd0;
        rif.req_data[192 +: 64] = 64'h5555;
`ifdef REGFILE_ARB_ZERO_REG_EN
        exp_en   = 1'b0;
        exp_addr = 3'd5;
`else
        exp_en   = 1'b1;
        exp_addr = 3'd0;
`endif
        #1;
        check("zero_ready", rif.req_ready, 4'b1000);
        after_edge();
        check("zero_wr_en", wr_en, exp_en);
        check("zero_addr", wr_addr, exp_addr);
        check("zero_rr_ptr", dut.rr_ptr, 3);
        @(negedge clk);
        rif.req_valid = 4'b0000;

        // Asynchronous reset while a write strobe is high
        @(negedge clk);
        rif.req_valid = 4'b0010;
        after_edge();
        check("mid_wr_en_before", wr_en, 1);
        check("mid_rr_before", dut.rr_ptr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_wr_en_after", wr_en, 0);
        check("mid_rr_ptr", dut.rr_ptr, 3);
        check("mid_ready", rif.req_ready, 0);
        @(negedge clk);
        rif.req_valid = 4'b0000;
        rst_n         = 1'b1;
        after_edge();
        check("post_rst_wr_en", wr_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
